// File: rtl/truth_table_scanner.sv
// Purpose : drives every input code x = 0..2^N-1 into a downstream SOP network, samples z for each and publishes the truth table.
// Latency : with the start edge as edge 0, done pulses and table_dat updates after edge 2^N*SETTLE; each x is held SETTLE cycles.
// Backpr. : no backpressure; start is taken only in IDLE with done low, and is otherwise dropped (never queued).
//
// Ports:
//   clock, reset  - single clock, synchronous active-high reset
//   start         - scan request, honoured only when idle
//   z             - downstream network output for the current x
//   x             - code driven to the network (x[N-1] is MSB)
//   busy          - high while a scan is in progress
//   done          - one-cycle pulse when table_dat has just been updated
//   table_dat     - truth table, bit i = z sampled while x == i. The name
//                   "table" is a reserved word in SystemVerilog, hence the suffix.
//   ones          - (only with SCANNER_MINTERM_COUNT_EN) number of 1 bits in
//                   table_dat, i.e. minterms of the canonical SOP
//
// Optional feature macro: SCANNER_MINTERM_COUNT_EN
module truth_table_scanner #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              z,
    output logic [N-1:0]      x,
    output logic              busy,
    output logic              done,
    output logic [(1<<N)-1:0] table_dat
`ifdef SCANNER_MINTERM_COUNT_EN
    ,
    output logic [N:0]        ones
`endif
);

    localparam int TW = 1 << N;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);
    localparam logic [N-1:0]  X_LAST    = {N{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [TW-1:0]   acc_q, acc_d;
    logic [TW-1:0]   table_d;
    logic            busy_d;
    logic            done_d;
`ifdef SCANNER_MINTERM_COUNT_EN
    logic [N:0]      cnt_q, cnt_d;
    logic [N:0]      ones_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x;
        wait_d  = wait_q;
        acc_d   = acc_q;
        table_d = table_dat;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef SCANNER_MINTERM_COUNT_EN
        cnt_d   = cnt_q;
        ones_d  = ones;
`endif
        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a start seen there is dropped.
                if (start && !done) begin
                    state_d = SCAN;
                    x_d     = '0;
                    wait_d  = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
`ifdef SCANNER_MINTERM_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SCAN: begin
                if (wait_q != WAIT_LAST) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    acc_d[x] = z;
`ifdef SCANNER_MINTERM_COUNT_EN
                    cnt_d    = cnt_q + {{N{1'b0}}, z};
`endif
                    if (x != X_LAST) begin
                        x_d    = x + 1'b1;
                        wait_d = '0;
                    end else begin
                        // acc_d already holds the final sample, so the table
                        // is published whole in a single edge.
                        table_d = acc_d;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        x_d     = '0;
                        state_d = IDLE;
`ifdef SCANNER_MINTERM_COUNT_EN
                        ones_d  = cnt_d;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            x         <= '0;
            wait_q    <= '0;
            acc_q     <= '0;
            table_dat <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SCANNER_MINTERM_COUNT_EN
            cnt_q     <= '0;
            ones      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x         <= x_d;
            wait_q    <= wait_d;
            acc_q     <= acc_d;
            table_dat <= table_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef SCANNER_MINTERM_COUNT_EN
            cnt_q     <= cnt_d;
            ones      <= ones_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Purpose : exercises two scanner instances (N=2/SETTLE=1 and N=3/SETTLE=2) against a cycle-trace model.
// Latency : model expects done 2^N*SETTLE edges after the start edge.
// Backpr. : none; start is held or pulsed from the bench.
module tb_truth_table_scanner;

    typedef struct packed {
        logic [2:0] x;
        logic       busy;
        logic       done;
        logic [7:0] tbl;
        logic [3:0] ones;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start2, start3;
    logic [3:0] f2;
    logic [7:0] f3;

    logic [1:0] x2;
    logic       busy2, done2;
    logic [3:0] tbl2;
    logic [2:0] x3;
    logic       busy3, done3;
    logic [7:0] tbl3;
`ifdef SCANNER_MINTERM_COUNT_EN
    logic [2:0] ones2;
    logic [3:0] ones3;
`endif

    // Downstream network: an arbitrary function held as a lookup table.
    logic z2, z3;
    assign z2 = f2[x2];
    assign z3 = f3[x3];

    int errors = 0;
    int checks = 0;
    logic [7:0] prev2, prev3;

    always #5 clock = ~clock;

    truth_table_scanner #(.N(2), .SETTLE(1)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .z(z2),
        .x(x2), .busy(busy2), .done(done2), .table_dat(tbl2)
`ifdef SCANNER_MINTERM_COUNT_EN
        , .ones(ones2)
`endif
    );

    truth_table_scanner #(.N(3), .SETTLE(2)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3), .z(z3),
        .x(x3), .busy(busy3), .done(done3), .table_dat(tbl3)
`ifdef SCANNER_MINTERM_COUNT_EN
        , .ones(ones3)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] ones_of(input logic [7:0] v);
`ifdef SCANNER_MINTERM_COUNT_EN
        return 4'($countones(v));
`else
        return 4'(v & 8'h0);
`endif
    endfunction

    function automatic obs_t sample(input int s);
        obs_t o;
        o = '0;
        if (s == 2) begin
            o.x = {1'b0, x2}; o.busy = busy2; o.done = done2; o.tbl = {4'b0, tbl2};
`ifdef SCANNER_MINTERM_COUNT_EN
            o.ones = {1'b0, ones2};
`endif
        end else begin
            o.x = x3; o.busy = busy3; o.done = done3; o.tbl = tbl3;
`ifdef SCANNER_MINTERM_COUNT_EN
            o.ones = ones3;
`endif
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d busy=%b done=%b table=%h ones=%0d", o.x, o.busy, o.done, o.tbl, o.ones);
    endfunction

    function automatic int n_of(input int s);
        return (s == 2) ? 2 : 3;
    endfunction

    function automatic int settle_of(input int s);
        return (s == 2) ? 1 : 2;
    endfunction

    // Expected trace from the cycle after the start edge: each code t/SETTLE
    // for 2^N*SETTLE cycles, then the done cycle, then one idle cycle.
    task automatic model_scan(input int s, input logic [7:0] f, input logic [7:0] prev,
                              output obs_t q[$]);
        int   n      = n_of(s);
        int   settle = settle_of(s);
        int   ncyc   = (1 << n) * settle;
        logic [7:0] fm = (n == 2) ? {4'b0, f[3:0]} : f;
        obs_t e;
        q = {};
        for (int t = 0; t < ncyc; t++) begin
            e.x = 3'(t / settle); e.busy = 1'b1; e.done = 1'b0; e.tbl = prev; e.ones = ones_of(prev);
            q.push_back(e);
        end
        e.x = 3'd0; e.busy = 1'b0; e.done = 1'b1; e.tbl = fm; e.ones = ones_of(fm);
        q.push_back(e);
        e.done = 1'b0;
        q.push_back(e);
    endtask

    // Drives one scan and records the DUT trace; hold keeps start high
    // through the done cycle and the following edge.
    task automatic run_scan(input int s, input logic [7:0] f, input bit hold, output obs_t q[$]);
        int ncyc = (1 << n_of(s)) * settle_of(s);
        q = {};
        if (s == 2) begin f2 = f[3:0]; start2 = 1'b1; end
        else        begin f3 = f;      start3 = 1'b1; end
        tick();
        if (!hold) begin start2 = 1'b0; start3 = 1'b0; end
        for (int t = 0; t <= ncyc + 1; t++) begin
            q.push_back(sample(s));
            if (t <= ncyc) tick();
        end
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        obs_t zero;
        zero = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int s = 2; s <= 3; s++) begin
            checks++;
            if (sample(s) !== zero) begin
                errors++;
                $display("FAIL reset dut%0d: got %s, expected %s", s, fmt(sample(s)), fmt(zero));
            end
        end
        prev2 = '0; prev3 = '0;
        tick();
    endtask

    task automatic test_directed();
        obs_t got[$], exp[$];
        logic [7:0] fs [3];
        fs[0] = 8'h08;  // z = x1 & x0
        fs[1] = 8'h06;  // z = x1 ^ x0
        fs[2] = 8'hE8;  // majority of three
        for (int k = 0; k < 3; k++) begin
            int s = (k == 2) ? 3 : 2;
            model_scan(s, fs[k], (s == 2) ? prev2 : prev3, exp);
            run_scan(s, fs[k], 1'b0, got);
            if (s == 2) prev2 = fs[k]; else prev3 = fs[k];
            foreach (exp[i]) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL directed%0d cycle %0d: got %s, expected %s", k, i, fmt(got[i]), fmt(exp[i]));
                end
            end
            tick();
        end
    endtask

    task automatic test_start_held();
        obs_t got[$], exp[$];
        obs_t idle;
        // Prior table 1000 must stay visible until the new done cycle.
        run_scan(2, 8'h08, 1'b0, got);
        prev2 = 8'h08;
        model_scan(2, 8'h05, prev2, exp);
        run_scan(2, 8'h05, 1'b1, got);
        prev2 = 8'h05;
        foreach (exp[i]) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL start_held cycle %0d: got %s, expected %s", i, fmt(got[i]), fmt(exp[i]));
            end
        end
        idle = exp[exp.size() - 1];
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sample(2) !== idle) begin
                errors++;
                $display("FAIL start_held idle %0d: got %s, expected %s", c, fmt(sample(2)), fmt(idle));
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        obs_t got[$], exp[$];
        obs_t zero;
        zero = '0;
        f2 = 4'($urandom_range(0, 15));
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick(); tick();
        checks++;
        if (x2 !== 2'd2) begin
            errors++;
            $display("FAIL mid_scan x before reset: got %0d, expected 2", x2);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev2 = '0; prev3 = '0;
        checks++;
        if (sample(2) !== zero) begin
            errors++;
            $display("FAIL mid_scan after reset: got %s, expected %s", fmt(sample(2)), fmt(zero));
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (sample(2) !== zero) begin
                errors++;
                $display("FAIL mid_scan aborted %0d: got %s, expected %s", c, fmt(sample(2)), fmt(zero));
            end
        end
        model_scan(2, {4'b0, f2}, prev2, exp);
        run_scan(2, {4'b0, f2}, 1'b0, got);
        prev2 = {4'b0, f2};
        foreach (exp[i]) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL mid_scan rescan cycle %0d: got %s, expected %s", i, fmt(got[i]), fmt(exp[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got[$], exp[$];
        for (int k = 0; k < 2; k++) begin
            logic [7:0] f = 8'($urandom);
            model_scan(3, f, prev3, exp);
            run_scan(3, f, 1'b0, got);
            prev3 = f;
            foreach (exp[i]) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL back_to_back%0d cycle %0d: got %s, expected %s", k, i, fmt(got[i]), fmt(exp[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        obs_t got[$], exp[$];
        for (int k = 0; k < 10; k++) begin
            int         s    = ($urandom_range(0, 1) == 0) ? 2 : 3;
            logic [7:0] f    = 8'($urandom);
            bit         hold = 1'($urandom_range(0, 1));
            if (s == 2) f[7:4] = 4'b0;
            model_scan(s, f, (s == 2) ? prev2 : prev3, exp);
            run_scan(s, f, hold, got);
            if (s == 2) prev2 = f; else prev3 = f;
            foreach (exp[i]) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL random%0d dut%0d cycle %0d: got %s, expected %s", k, s, i, fmt(got[i]), fmt(exp[i]));
                end
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        f2     = '0;
        f3     = '0;
        prev2  = '0;
        prev3  = '0;
        #1;
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
